// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared definitions for the fetch queue:
//   - field widths of a fetch packet (PC 32, data 64, slot mask 2)
//   - slot offsets inside the 64-bit data word (slot 0 high, slot 1 low)
//   - the bubble constant driven on an empty or invalid slot
//   - the packed packet record stored per queue entry (98 bits)
//   Optional feature macro used by fetch_queue: FETCHQ_BYPASS_EN
//   (zero-latency pass-through of a packet into an empty queue).
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int PC_W      = 32;
  localparam int DATA_W    = 64;
  localparam int MASK_W    = 2;
  localparam int INST_W    = 32;
  localparam int SLOT0_LSB = 32;
  localparam int SLOT1_LSB = 0;

  localparam logic [INST_W-1:0] BUBBLE_INST = '0;

  // Field order gives entry bits [97:66] pc, [65:2] data, [1:0] mask.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } fetch_pkt_t;

  // Instruction for one slot, or the bubble when that slot is not valid.
  function automatic logic [INST_W-1:0] slot_inst(input fetch_pkt_t pkt,
                                                  input logic       slot1);
    logic [INST_W-1:0] inst;
    inst = slot1 ? pkt.data[SLOT1_LSB +: INST_W] : pkt.data[SLOT0_LSB +: INST_W];
    return pkt.mask[slot1] ? inst : BUBBLE_INST;
  endfunction

endpackage

// File: rtl/fetchq_mem.sv
// -----------------------------------------------------------------------------
// fetchq_mem
//   DEPTH x 98-bit packet storage: one synchronous write port, one
//   combinational read port. Contents are not cleared by reset; the queue
//   control never presents an entry that has not been written.
//   Ports:
//     clock_i  rising-edge clock
//     wr_en    write strobe
//     wr_addr  entry written when wr_en is high
//     wr_pkt   packet written
//     rd_addr  entry presented on rd_pkt
//     rd_pkt   packet stored at rd_addr (combinational)
// -----------------------------------------------------------------------------
module fetchq_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  fetch_pkt_t                 wr_pkt,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output fetch_pkt_t                 rd_pkt
);

  localparam int AW = $clog2(DEPTH);

  fetch_pkt_t entry_q [DEPTH];

  // One register per entry so each has its own decoded write enable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fetch_pkt_t slot_reg;

    always_ff @(posedge clock_i) begin
      if (wr_en && (wr_addr == AW'(gi))) begin
        slot_reg <= wr_pkt;
      end
    end

    assign entry_q[gi] = slot_reg;
  end

  assign rd_pkt = entry_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupling queue between F2/imem and the decode buffer. Stores fetch
//   packets (PC, two instructions, slot valid mask), shows the oldest one to
//   decode, throttles F1 while keeping one slot free for the packet already
//   in flight, and on a redirect discards both the queue and that in-flight
//   wrong-path packet (the "shadow" cycle after a flush).
//   Optional feature: define FETCHQ_BYPASS_EN to let a packet arriving at an
//   empty queue appear on the head outputs in the same cycle; if decode
//   takes it in that cycle it is never written.
//   Ports:
//     clock_i, reset_i            clock, synchronous active-high reset
//     flush_i                     redirect: clear queue, drop next push
//     push_valid_i/pc/data/mask   packet delivered by F2
//     pop_ready_i                 decode consumes the head packet
//     fetch_we_o                  F1 may issue a new fetch
//     inst0_o/inst1_o,
//     valid0_o/valid1_o, pc_o     head packet (all zero when empty)
//     count_o                     occupied entries
//     overflow_o                  sticky: a push was dropped while full
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  input  logic [PC_W-1:0]          push_pc_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic [MASK_W-1:0]        push_mask_i,
  input  logic                     pop_ready_i,
  output logic                     fetch_we_o,
  output logic [INST_W-1:0]        inst0_o,
  output logic [INST_W-1:0]        inst1_o,
  output logic                     valid0_o,
  output logic                     valid1_o,
  output logic [PC_W-1:0]          pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  // F1 may only advance while two or more slots are free: one for the
  // packet it is about to fetch and one for the packet already in imem.
  localparam logic [CW-1:0] FETCH_LIMIT = CW'(DEPTH - 2);

  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          shadow_reg;
  logic          overflow_reg;

  fetch_pkt_t push_pkt;
  fetch_pkt_t head_pkt;
  fetch_pkt_t shown_pkt;

  logic is_empty;
  logic is_full;
  logic push_offered;
  logic pop_fire;
  logic push_fire;
  logic push_drop;
  logic bypass_hit;
  logic bypass_take;
  logic mem_we;
  logic show_valid;

  assign push_pkt = '{pc: push_pc_i, data: push_data_i, mask: push_mask_i};

  assign is_empty     = (count_reg == '0);
  assign is_full      = (count_reg == FULL_COUNT);
  // A push is only considered outside a flush and its shadow cycle.
  assign push_offered = push_valid_i && !flush_i && !shadow_reg;

`ifdef FETCHQ_BYPASS_EN
  assign bypass_hit = push_offered && is_empty;
`else
  assign bypass_hit = 1'b0;
`endif
  // Bypassed packet consumed by decode directly: it never occupies an entry.
  assign bypass_take = bypass_hit && pop_ready_i;

  assign pop_fire  = pop_ready_i && !is_empty && !flush_i;
  assign push_fire = push_offered && (!is_full || pop_fire);
  assign push_drop = push_offered && is_full && !pop_fire;
  assign mem_we    = push_fire && !bypass_take && !reset_i;

  fetchq_mem #(.DEPTH(DEPTH)) u_mem (
    .clock_i (clock_i),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_reg),
    .wr_pkt  (push_pkt),
    .rd_addr (rd_ptr_reg),
    .rd_pkt  (head_pkt)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      shadow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      shadow_reg <= 1'b1;
    end else begin
      shadow_reg <= 1'b0;
      if (mem_we) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({mem_we, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Head view: stored head, the bypassed packet, or an all-zero bubble.
  assign show_valid = !reset_i && (!is_empty || bypass_hit);
  assign shown_pkt  = bypass_hit ? push_pkt : head_pkt;

  assign valid0_o = show_valid && shown_pkt.mask[0];
  assign valid1_o = show_valid && shown_pkt.mask[1];
  assign inst0_o  = show_valid ? slot_inst(shown_pkt, 1'b0) : BUBBLE_INST;
  assign inst1_o  = show_valid ? slot_inst(shown_pkt, 1'b1) : BUBBLE_INST;
  assign pc_o     = show_valid ? shown_pkt.pc : '0;

  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;
  assign fetch_we_o = !reset_i && !flush_i && (count_reg <= FETCH_LIMIT);

endmodule
